gshare_branch_predictor: RTL and testbench
==========================================

Name: gshare_branch_predictor

Overview:
- Fetch-stage next-PC predictor. It replaces the fixed pc+4 that currently drives the next-PC mux and the IF/ID predicted-PC path.
- Combinational lookup on the current fetch PC.
- Trained at the clock edge by the resolved outcome from the EX stage: a gshare pattern history table (2-bit counters) plus a direct-mapped branch target buffer.
- A misprediction is still detected downstream by comparing the resolved PC against the IF/ID PC. This block only supplies the guess.

Parameters:
- BTB_ENTRIES, 32, number of direct-mapped BTB entries (power of 2, ≥2).
- GHR_WIDTH, 5, global history length in bits; the PHT has 2^GHR_WIDTH counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- pc  input  32  current fetch PC.
- predicted_pc  output  32  predicted next fetch PC (combinational).
- lookup_ghr  output  GHR_WIDTH  GHR value used for this lookup; the pipeline carries it to EX.
- update_valid  input  1  valid resolved control-flow instruction in EX (already gated by ~invalid).
- update_is_branch  input  1  1 = conditional branch, 0 = JAL/JALR.
- update_pc  input  32  PC of the resolved instruction.
- update_taken  input  1  resolved direction (driven 1 for jumps).
- update_target  input  32  resolved target PC.
- update_ghr  input  GHR_WIDTH  lookup_ghr carried with that instruction.

Behaviour:
- Indexing:
  - BTB index = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - BTB tag = pc[31:IDX+2].
  - PHT index = pc[GHR_WIDTH+1:2] XOR GHR.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - predicted_pc = btb_target if hit & (is_jump | pht[idx][1]); otherwise pc+4.
  - pc+4 wraps modulo 2^32.
  - lookup_ghr = current GHR.
- Update (at posedge clk when update_valid=1), all in the same edge:
  - If update_is_branch: the PHT counter at index update_pc[GHR_WIDTH+1:2] XOR update_ghr saturates up (taken) or down (not taken). 11 stays 11; 00 stays 00.
  - If update_is_branch: GHR <= {GHR[GHR_WIDTH-2:0], update_taken}. The GHR updates only at resolution (non-speculative).
  - If update_taken: the BTB entry for update_pc is overwritten with valid=1, tag, update_target, and is_jump = ~update_is_branch. This includes replacing a conflicting tag.
  - Not-taken branch: BTB unchanged.
  - update_valid=0: no state change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Simultaneous lookup and update to the same entry: the lookup sees pre-update contents. No bypass.
- Reset (asynchronous, any time, including mid-update):
  - All BTB valid = 0.
  - All PHT counters = 01.
  - GHR = 0.
  - Consequence: predicted_pc = pc+4 and lookup_ghr = 0 while reset=0 and until the first taken update.
- A pipeline stall does not affect the block: pc is held upstream and lookup is stateless.

Optional Feature:
- BPRED_GSHARE_EN defined: PHT index uses XOR with the GHR as above.
- Macro undefined (bimodal mode):
  - PHT index = pc[GHR_WIDTH+1:2] only (update side uses update_pc likewise).
  - GHR register is not implemented; lookup_ghr is tied to 0 and update_ghr is ignored.

Decomposition:
- Shared package: 2-bit counter encodings (SNT/WNT/WT/ST), counter reset value, BTB entry struct {valid, tag, target, is_jump}.
- One sub-module, branch_target_buffer:
  - direct-mapped storage with combinational read (hit, target, is_jump);
  - synchronous write port;
  - async active-low clear.
- The PHT, GHR and next-PC mux stay in the top.

Test Plan:
- Reset then pc=0x100 -> predicted_pc=0x104, lookup_ghr=0; repeat for pc=0xFFFFFFFC -> predicted_pc=0x00000000.
- One update {is_branch=0, pc=0x40, taken=1, target=0x200}, then pc=0x40 -> 0x200. pc=0xC0 (same index, different tag) -> 0xC4.
- Branch at 0x80, target 0x10:
  - first taken update (counter 01->10) -> lookup at 0x80 predicts 0x10;
  - one not-taken update -> predicts 0x84;
  - three taken then four not-taken -> counter saturates at 11, then at 00; prediction follows (0x84 at the end).
- GHR shifting (gshare build): updates T,T,N,T from reset -> lookup_ghr=5'b01101. A jump update leaves the GHR unchanged.
- In the same cycle, pc=0x80 is presented and a taken update for 0x80 is applied -> predicted_pc is pc+4 that cycle and the target the next cycle.
- Assert reset low in the middle of the update cycle -> outputs immediately return to pc+4 / ghr 0; the update is lost after release.

Source files
------------

// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit counter states and the BTB entry layout.
package gshare_branch_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = CTR_WNT;

    // Widest tag any legal BTB size needs (2 entries -> pc[31:3]); narrower tags are zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic                 is_jump;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken && c != CTR_ST)
            n = ctr_t'(c + 2'd1);
        else if (!taken && c != CTR_SNT)
            n = ctr_t'(c - 2'd1);
        return n;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational read, synchronous write, async active-low clear.
module branch_target_buffer
    import gshare_branch_predictor_pkg::*;
#(
    parameter  int ENTRIES = 32,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [31:0]      target,
    output logic             is_jump,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic             wr_is_jump
);

    btb_entry_t mem [ENTRIES];
    btb_entry_t rd_entry;
    btb_entry_t wr_entry;

    assign rd_entry = mem[rd_idx];
    assign hit      = rd_entry.valid && (rd_entry.tag == TAG_MAX_W'(rd_tag));
    assign target   = rd_entry.target;
    assign is_jump  = rd_entry.is_jump;

    assign wr_entry.valid   = 1'b1;
    assign wr_entry.tag     = TAG_MAX_W'(wr_tag);
    assign wr_entry.target  = wr_target;
    assign wr_entry.is_jump = wr_is_jump;

    // A write always replaces the slot, even when it holds a different tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage next-PC predictor: 2-bit PHT plus direct-mapped BTB, trained non-speculatively from EX.
// Define BPRED_GSHARE_EN for gshare (PC xor GHR) indexing; otherwise the PHT is bimodal with no GHR.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc,
    output logic [31:0]          predicted_pc,
    output logic [GHR_WIDTH-1:0] lookup_ghr,
    input  logic                 update_valid,
    input  logic                 update_is_branch,
    input  logic [31:0]          update_pc,
    input  logic                 update_taken,
    input  logic [31:0]          update_target,
    input  logic [GHR_WIDTH-1:0] update_ghr
);

    localparam int IDX         = $clog2(BTB_ENTRIES);
    localparam int PHT_ENTRIES = 1 << GHR_WIDTH;

    ctr_t                 pht [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0] ghr;
    logic [GHR_WIDTH-1:0] lk_idx;
    logic [GHR_WIDTH-1:0] up_idx;
    logic                 btb_hit;
    logic                 btb_is_jump;
    logic [31:0]          btb_target;
    logic                 pred_taken;
    logic                 unused_bits;

`ifdef BPRED_GSHARE_EN
    // History advances only on resolved branches, so the GHR is never repaired.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ghr <= '0;
        else if (update_valid && update_is_branch)
            ghr <= {ghr[GHR_WIDTH-2:0], update_taken};
    end

    assign lk_idx      = pc[GHR_WIDTH+1:2] ^ ghr;
    assign up_idx      = update_pc[GHR_WIDTH+1:2] ^ update_ghr;
    assign unused_bits = ^update_pc[1:0];
`else
    assign ghr         = '0;
    assign lk_idx      = pc[GHR_WIDTH+1:2];
    assign up_idx      = update_pc[GHR_WIDTH+1:2];
    assign unused_bits = ^{update_pc[1:0], update_ghr};
`endif

    assign lookup_ghr = ghr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++)
                pht[i] <= CTR_RESET;
        end else if (update_valid && update_is_branch) begin
            pht[up_idx] <= ctr_next(pht[up_idx], update_taken);
        end
    end

    branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (pc[IDX+1:2]),
        .rd_tag     (pc[31:IDX+2]),
        .hit        (btb_hit),
        .target     (btb_target),
        .is_jump    (btb_is_jump),
        .wr_en      (update_valid && update_taken),
        .wr_idx     (update_pc[IDX+1:2]),
        .wr_tag     (update_pc[31:IDX+2]),
        .wr_target  (update_target),
        .wr_is_jump (!update_is_branch)
    );

    // Lookup reads pre-update state; a same-cycle update becomes visible next cycle.
    assign pred_taken   = btb_hit && (btb_is_jump || pht[lk_idx][1]);
    assign predicted_pc = pred_taken ? btb_target : pc + 32'd4;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor; a small reference model feeds a scoreboard of expected lookups.
module tb_gshare_branch_predictor;

`ifdef BPRED_GSHARE_EN
    localparam bit GSH = 1'b1;
`else
    localparam bit GSH = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] predicted_pc;
    logic [4:0]  lookup_ghr;
    logic        update_valid;
    logic        update_is_branch;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [4:0]  update_ghr;

    gshare_branch_predictor #(.BTB_ENTRIES(32), .GHR_WIDTH(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .predicted_pc     (predicted_pc),
        .lookup_ghr       (lookup_ghr),
        .update_valid     (update_valid),
        .update_is_branch (update_is_branch),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_ghr       (update_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 32-entry BTB indexed by pc[6:2], tag pc[31:7]; 32 two-bit counters.
    logic [1:0]  m_pht [32];
    logic        m_v   [32];
    logic [24:0] m_tag [32];
    logic [31:0] m_tgt [32];
    logic        m_j   [32];
    logic [4:0]  m_ghr;

    logic [31:0] q_pc  [$];
    logic [4:0]  q_ghr [$];
    string       q_name[$];

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_pht[i] = 2'b01;
            m_v[i]   = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
            m_j[i]   = 1'b0;
        end
        m_ghr = '0;
    endtask

    function automatic logic [31:0] m_pred(input logic [31:0] p);
        logic [4:0] bi;
        logic [4:0] pi;
        logic       hit;
        bi  = p[6:2];
        pi  = p[6:2] ^ (GSH ? m_ghr : 5'd0);
        hit = m_v[bi] && (m_tag[bi] == p[31:7]);
        if (hit && (m_j[bi] || m_pht[pi][1]))
            return m_tgt[bi];
        return p + 32'd4;
    endfunction

    task automatic m_update(input logic br, input logic [31:0] p, input logic t,
                            input logic [31:0] tg, input logic [4:0] g);
        logic [4:0] pi;
        logic [4:0] bi;
        pi = p[6:2] ^ (GSH ? g : 5'd0);
        bi = p[6:2];
        if (br) begin
            if (t && m_pht[pi] != 2'b11)
                m_pht[pi] = m_pht[pi] + 2'b01;
            else if (!t && m_pht[pi] != 2'b00)
                m_pht[pi] = m_pht[pi] - 2'b01;
            if (GSH)
                m_ghr = {m_ghr[3:0], t};
        end
        if (t) begin
            m_v[bi]   = 1'b1;
            m_tag[bi] = p[31:7];
            m_tgt[bi] = tg;
            m_j[bi]   = !br;
        end
    endtask

    task automatic expect_lookup(input logic [31:0] p, input string name);
        q_pc.push_back(m_pred(p));
        q_ghr.push_back(m_ghr);
        q_name.push_back(name);
    endtask

    task automatic check();
        logic [31:0] ep;
        logic [4:0]  eg;
        string       nm;
        n_asserts++;
        assert (q_pc.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty got %0d entries expected >0", q_pc.size());
        end
        if (q_pc.size() > 0) begin
            ep = q_pc.pop_front();
            eg = q_ghr.pop_front();
            nm = q_name.pop_front();
            n_asserts++;
            assert (predicted_pc === ep) else begin
                n_fail++;
                $error("FAIL %s predicted_pc got %08h expected %08h", nm, predicted_pc, ep);
            end
            n_asserts++;
            assert (lookup_ghr === eg) else begin
                n_fail++;
                $error("FAIL %s lookup_ghr got %05b expected %05b", nm, lookup_ghr, eg);
            end
        end
    endtask

    task automatic look(input logic [31:0] p, input string name);
        @(negedge clk);
        pc = p;
        expect_lookup(p, name);
        #1 check();
    endtask

    task automatic upd(input logic br, input logic [31:0] p, input logic t, input logic [31:0] tg);
        logic [4:0] g;
        @(negedge clk);
        g                = m_ghr;
        update_valid     = 1'b1;
        update_is_branch = br;
        update_pc        = p;
        update_taken     = t;
        update_target    = tg;
        update_ghr       = g;
        @(posedge clk);
        m_update(br, p, t, tg, g);
        #1 update_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset            = 1'b0;
        pc               = '0;
        update_valid     = 1'b0;
        update_is_branch = 1'b0;
        update_pc        = '0;
        update_taken     = 1'b0;
        update_target    = '0;
        update_ghr       = '0;
        m_reset();

        // reset state, including pc+4 wrap
        look(32'h0000_0100, "in_reset_pc100");
        @(negedge clk);
        reset = 1'b1;
        look(32'h0000_0100, "rst_pc100");
        look(32'hFFFF_FFFC, "rst_wrap");

        // jump fills BTB; aliasing tag misses; conflicting tag replaces
        upd(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0200);
        look(32'h0000_0040, "jump_hit");
        look(32'h0000_00C0, "alias_miss");
        upd(1'b0, 32'h0000_00C0, 1'b1, 32'h0000_0300);
        look(32'h0000_00C0, "replace_hit");
        look(32'h0000_0040, "replaced_miss");

        // counter training and saturation for a branch at 0x80
        do_reset();
        upd(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0010);
        look(32'h0000_0080, "br_first_taken");
        upd(1'b1, 32'h0000_0080, 1'b0, 32'h0000_0010);
        look(32'h0000_0080, "br_one_nt");
        for (int i = 0; i < 3; i++) begin
            upd(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0010);
            look(32'h0000_0080, "br_sat_up");
        end
        for (int i = 0; i < 4; i++) begin
            upd(1'b1, 32'h0000_0080, 1'b0, 32'h0000_0010);
            look(32'h0000_0080, "br_sat_down");
        end

        // history shifting T,T,N,T then a jump that must not shift
        do_reset();
        upd(1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600);
        upd(1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600);
        upd(1'b1, 32'h0000_0500, 1'b0, 32'h0000_0600);
        upd(1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600);
        look(32'h0000_0500, "ghr_ttnt");
        upd(1'b0, 32'h0000_0700, 1'b1, 32'h0000_0900);
        look(32'h0000_0700, "ghr_after_jump");

        // same-cycle lookup and update: old contents now, new contents next cycle
        do_reset();
        @(negedge clk);
        pc               = 32'h0000_0080;
        update_valid     = 1'b1;
        update_is_branch = 1'b0;
        update_pc        = 32'h0000_0080;
        update_taken     = 1'b1;
        update_target    = 32'h0000_0010;
        update_ghr       = m_ghr;
        expect_lookup(32'h0000_0080, "same_cycle_pre");
        #1 check();
        @(posedge clk);
        m_update(1'b0, 32'h0000_0080, 1'b1, 32'h0000_0010, update_ghr);
        #1 update_valid = 1'b0;
        expect_lookup(32'h0000_0080, "same_cycle_post");
        check();

        // reset asserted in the middle of an update cycle
        upd(1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600);
        @(negedge clk);
        pc               = 32'h0000_0300;
        update_valid     = 1'b1;
        update_is_branch = 1'b0;
        update_pc        = 32'h0000_0300;
        update_taken     = 1'b1;
        update_target    = 32'h0000_0400;
        update_ghr       = m_ghr;
        #2 reset = 1'b0;
        m_reset();
        expect_lookup(32'h0000_0300, "mid_reset_now");
        #1 check();
        @(posedge clk);
        @(negedge clk);
        update_valid = 1'b0;
        reset        = 1'b1;
        look(32'h0000_0300, "mid_reset_lost");
        look(32'h0000_0080, "mid_reset_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
